// File: rtl/switch_xor3_pkg.sv
// Shared constants and helpers for the three-way light-switch controller.
package switch_xor3_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

  // Counter must be able to hold DEBOUNCE_CYCLES itself.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One raw switch pin: two-flop synchronizer followed by a consecutive-sample
// debouncer that only accepts a new level after DEBOUNCE_CYCLES agreeing clocks.
module switch_debounce
  import switch_xor3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            stable_q;
  logic            stable_d;
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  // Any return of the synchronized level to the stable value restarts the count.
  always_comb begin
    stable_d = stable_q;
    count_d  = count_q;
    if (sync2_q == stable_q) begin
      count_d = '0;
    end else if (count_q == CntLast) begin
      stable_d = sync2_q;
      count_d  = '0;
    end else begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      count_q  <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      count_q  <= count_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/switch_xor3.sv
// Three-way light-switch controller: three debounced switches drive a lamp
// with their odd parity, plus a one-clock pulse whenever the lamp changes.
module switch_xor3
  import switch_xor3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  output logic y,
  output logic y_toggle
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("switch_xor3: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [2:0] rawSw;
  logic [2:0] stableSw;
  logic       parity_d;
  logic       y_q;
  logic       yToggle_q;

  assign rawSw = {x1, x2, x3};

  for (genvar i = 0; i < 3; i++) begin : g_sw
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (rawSw[i]),
      .stable(stableSw[i])
    );
  end

  assign parity_d = ^stableSw;

  // Toggle pulse lines up with the cycle in which y first shows its new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= 1'b0;
      yToggle_q <= 1'b0;
    end else begin
      y_q       <= parity_d;
      yToggle_q <= (parity_d != y_q);
    end
  end

  assign y        = y_q;
  assign y_toggle = yToggle_q;

endmodule

// File: tb/tb_switch_xor3.sv
// Scoreboard bench: three controllers (DEBOUNCE_CYCLES 2, 1, 4) share stimulus;
// a window-based reference model queues expected outputs, a monitor compares.
module tb_switch_xor3;

  localparam int DVAL [3] = '{2, 1, 4};

  logic clk = 1'b0;
  logic rst_n;
  logic x1, x2, x3;
  logic [2:0] yW;
  logic [2:0] togW;

  int compared = 0;
  int mismatched = 0;

  logic [5:0] expQ[$];

  always #5 clk = ~clk;

  switch_xor3 #(.DEBOUNCE_CYCLES(DVAL[0])) u_dut0 (
    .clk(clk), .rst_n(rst_n), .x1(x1), .x2(x2), .x3(x3), .y(yW[0]), .y_toggle(togW[0]));
  switch_xor3 #(.DEBOUNCE_CYCLES(DVAL[1])) u_dut1 (
    .clk(clk), .rst_n(rst_n), .x1(x1), .x2(x2), .x3(x3), .y(yW[1]), .y_toggle(togW[1]));
  switch_xor3 #(.DEBOUNCE_CYCLES(DVAL[2])) u_dut2 (
    .clk(clk), .rst_n(rst_n), .x1(x1), .x2(x2), .x3(x3), .y(yW[2]), .y_toggle(togW[2]));

  task automatic checkOutput(input string name, input int inst, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s inst%0d(D=%0d) got %b expected %b at %0t",
               name, inst, DVAL[inst], act, exp, $time);
    end
  endtask

  // Reference model: a switch's accepted level flips once the last D
  // synchronized samples (raw sampled two edges earlier) all disagree with it.
  bit   hist  [3][3][8];
  bit   mStab [3][3];
  bit   mY    [3];
  logic [2:0] mYv, mTv;

  always @(posedge clk) begin
    logic [2:0] xs;
    bit newY, allDiff;
    xs = {x1, x2, x3};
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        for (int n = 0; n < 3; n++) begin
          mStab[i][n] = 1'b0;
          for (int k = 0; k < 8; k++) hist[i][n][k] = 1'b0;
        end
        mY[i]  = 1'b0;
        mYv[i] = 1'b0;
        mTv[i] = 1'b0;
      end else begin
        newY   = mStab[i][0] ^ mStab[i][1] ^ mStab[i][2];
        mTv[i] = (newY != mY[i]);
        mY[i]  = newY;
        mYv[i] = newY;
        for (int n = 0; n < 3; n++) begin
          for (int k = 7; k > 0; k--) hist[i][n][k] = hist[i][n][k-1];
          hist[i][n][0] = xs[n];
          allDiff = 1'b1;
          for (int k = 2; k <= DVAL[i] + 1; k++)
            if (hist[i][n][k] == mStab[i][n]) allDiff = 1'b0;
          if (allDiff) mStab[i][n] = ~mStab[i][n];
        end
      end
    end
    expQ.push_back({mYv, mTv});
  end

  // Monitor: one expected entry per clock edge.
  initial begin
    logic [5:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL scoreboard_empty got 0 entries expected 1 at %0t", $time);
      end else begin
        e = expQ.pop_front();
        for (int i = 0; i < 3; i++) begin
          checkOutput("y", i, yW[i], e[3+i]);
          checkOutput("y_toggle", i, togW[i], e[i]);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] pattern, input int cycles);
    {x1, x2, x3} = pattern;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    logic [2:0] pat;
    rst_n = 1'b0;
    {x1, x2, x3} = 3'b111;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3'b111, 15);

    // Asynchronous assertion between edges must clear outputs at once.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("async_reset_y", i, yW[i], 1'b0);
      checkOutput("async_reset_tog", i, togW[i], 1'b0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3'b111, 12);

    for (int p = 0; p < 8; p++) applyStimulus(3'(p), 20);

    applyStimulus(3'b000, 12);
    applyStimulus(3'b010, 1);
    applyStimulus(3'b000, 12);
    applyStimulus(3'b010, 2);
    applyStimulus(3'b000, 12);

    applyStimulus(3'b110, 12);
    applyStimulus(3'b001, 12);
    applyStimulus(3'b000, 12);

    for (int k = 0; k < 10; k++) applyStimulus({2'b00, 1'(k % 2 == 0)}, 1);
    applyStimulus(3'b001, 15);

    for (int r = 0; r < 200; r++) begin
      pat = 3'($urandom_range(0, 7));
      applyStimulus(pat, $urandom_range(1, 8));
    end
    applyStimulus(3'b000, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
